prog_seq_detect_ctrl: RTL
=========================

Name: prog_seq_detect_ctrl

Overview:
Run-time programmable serial bit-sequence detector with a controlling FSM. Software loads a pattern of 1..MAX_LEN bits through a valid/ready config port, then arms and disarms scanning. While scanning, the block checks the qualified serial stream `a` for the pattern, pulses `detected` on each match and keeps a saturating match count. It replaces the hard-wired 4-bit and 6-bit FSM detectors wherever the pattern must change without resynthesis.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of the match counter.
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived; do not override).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-low: rst==0 at posedge resets the block.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the oldest (first-received) bit, bit [0] the newest.
- cfg_len  in  LEN_W  pattern length.
- cfg_err  out  1  one-cycle pulse: the config was rejected.
- start  in  1  arm scanning (level sampled each cycle).
- stop  in  1  disarm scanning.
- a  in  1  serial data bit.
- a_valid  in  1  `a` is valid this cycle.
- detected  out  1  one-cycle match pulse.
- det_count  out  CNT_W  saturating match count.
- busy  out  1  high in SCAN.

Behaviour:
- Reset values: state=UNCFG, pattern=0, len=0, history=0, fill=0, detected=0, det_count=0, cfg_err=0, busy=0. cfg_ready=1 after reset.
- Reset asserted mid-operation discards the configuration and returns the block to UNCFG.
- FSM states: UNCFG, READY, SCAN.
- UNCFG:
  - cfg_ready=1.
  - A handshake (cfg_valid & cfg_ready) with 1<=cfg_len<=MAX_LEN stores the pattern and length, then moves to READY.
  - A handshake with cfg_len==0 or cfg_len>MAX_LEN: cfg_err=1 next cycle, nothing is stored, state is unchanged.
  - start is ignored.
- READY:
  - cfg_ready=1. A config handshake is handled as in UNCFG; a valid config overwrites the stored one.
  - On start: go to SCAN, clear history, fill and det_count.
  - If cfg_valid and start are high in the same cycle, config wins and start is ignored.
- SCAN:
  - cfg_ready=0 and busy=1.
  - On a_valid:
    - history <= {history[MAX_LEN-2:0], a}.
    - fill <= min(fill+1, MAX_LEN).
    - match = (fill+1 >= len) and (history_next[len-1:0] == pattern[len-1:0]).
  - detected is registered: it is high in the cycle after the bit that completes a match, for one cycle. det_count increments on the same edge and saturates at all-ones.
  - Cycles with a_valid=0 do not advance history or fill.
  - On stop: go to READY. stop has priority over a simultaneous a_valid, and that bit is dropped. det_count holds its value.
  - start while in SCAN is ignored.
- Matches overlap by default: the history is not cleared after a match.
- cfg_err and detected are never high in the same cycle as a transition caused by reset.

Optional Feature:
- Macro: PROG_SEQ_DETECT_NO_OVERLAP_EN.
- When defined, a match sets fill to 0 on the same edge, so a following match needs len fresh bits and overlapping matches are suppressed.
- When undefined, overlapping matches are reported.

Decomposition:
- Package prog_seq_detect_pkg holds:
  - the state enum (UNCFG, READY, SCAN);
  - a function that checks a length against MAX_LEN.
- One sub-module, seq_match_window, holds the history shift register, the fill counter and the masked compare. It takes pattern, len, shift, clear and a, and outputs match.
- The controller holds the FSM, the config registers, the detected flop and the counter.

Test Plan:
- Overlap: cfg pattern=4'b1011, len=4 -> start -> stream 1,0,1,1,0,1,1 (a_valid=1) -> detected after bits 4 and 7, det_count=2. With PROG_SEQ_DETECT_NO_OVERLAP_EN: one pulse after bit 4, det_count=1.
- Len 6 with gaps: pattern=6'b110011 -> stream 1,1,0,0,1,1,0,0,1,1 with a_valid=0 every other cycle -> pulses after bits 6 and 10 only, det_count=2.
- Bad config: cfg_len=0, then cfg_len=9 (MAX_LEN=8) in UNCFG -> cfg_err pulses twice, state stays UNCFG, a start is then ignored (busy=0).
- Priority: in READY, cfg_valid and start in the same cycle -> config accepted, busy=0. In SCAN, stop with a_valid on the bit that would match -> no pulse, state READY.
- Saturation: CNT_W=2, pattern=1'b1, len=1, stream of five 1s -> five pulses, det_count stays at 3.
- Reset mid-scan: rst=0 for one cycle during SCAN -> all outputs at reset values next cycle, state UNCFG, cfg_ready=1, a later start is ignored until a new config is loaded.

Source files
------------

// File: rtl/prog_seq_detect_pkg.sv
// Shared types and helpers for the programmable sequence detector.
// Optional build macro PROG_SEQ_DETECT_NO_OVERLAP_EN is consumed by the match window.
package prog_seq_detect_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    READY = 2'd1,
    SCAN  = 2'd2
  } state_e;

  function automatic logic len_in_range(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_match_window.sv
// History shift register, fill counter and masked pattern compare.
// With PROG_SEQ_DETECT_NO_OVERLAP_EN defined, a match restarts the fill count.
module seq_match_window
  import prog_seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               shift,
  input  logic               clear,
  input  logic               a,
  output logic               match
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] history_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W:0]     fill_inc;

  assign history_next = {history[MAX_LEN-2:0], a};
  assign fill_inc     = {1'b0, fill} + (LEN_W+1)'(1);

  // Only the newest len bits take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign match = (fill_inc >= {1'b0, len}) && (((history_next ^ pattern) & mask) == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift) begin
      history <= history_next;
`ifdef PROG_SEQ_DETECT_NO_OVERLAP_EN
      if (match) fill <= '0;
      else if (fill != FILL_MAX) fill <= fill_inc[LEN_W-1:0];
`else
      if (fill != FILL_MAX) fill <= fill_inc[LEN_W-1:0];
`endif
    end
  end

endmodule

// File: rtl/prog_seq_detect_ctrl.sv
// Programmable serial sequence detector: config registers, control FSM, match counter.
// Build macro PROG_SEQ_DETECT_NO_OVERLAP_EN suppresses overlapping matches.
module prog_seq_detect_ctrl
  import prog_seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               a,
  input  logic               a_valid,
  output logic               detected,
  output logic [CNT_W-1:0]   det_count,
  output logic               busy,
  output state_e             state
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               cfg_hs;
  logic               cfg_ok;
  logic               shift;
  logic               clear;
  logic               match;

  // Config transfers on a cycle with cfg_valid & cfg_ready; cfg_ready does not depend on cfg_valid.
  assign cfg_ready = (state != SCAN);
  assign busy      = (state == SCAN);
  assign cfg_hs    = cfg_valid & cfg_ready;
  assign cfg_ok    = len_in_range(int'(cfg_len), MAX_LEN);
  assign shift     = busy & a_valid & ~stop;
  assign clear     = (state == READY) & start & ~cfg_valid;

  seq_match_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .pattern (pattern_q),
    .len     (len_q),
    .shift   (shift),
    .clear   (clear),
    .a       (a),
    .match   (match)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= UNCFG;
      pattern_q <= '0;
      len_q     <= '0;
      detected  <= 1'b0;
      det_count <= '0;
      cfg_err   <= 1'b0;
    end else begin
      detected <= shift & match;
      cfg_err  <= cfg_hs & ~cfg_ok;
      case (state)
        UNCFG, READY: begin
          if (cfg_hs) begin
            if (cfg_ok) begin
              pattern_q <= cfg_pattern;
              len_q     <= cfg_len;
              state     <= READY;
            end
          end else if (clear) begin
            state     <= SCAN;
            det_count <= '0;
          end
        end
        SCAN: begin
          if (stop) state <= READY;
          else if (shift && match && (det_count != '1)) det_count <= det_count + CNT_W'(1);
        end
        default: state <= UNCFG;
      endcase
    end
  end

endmodule
